// File: rtl/dvbs2hdlTransmitterCore_pkg.sv
// Shared DVB-S2 transmitter core types and constants.
// Holds the pi/2-BPSK amplitude, sample type and sign-mapping helper.
package dvbs2hdlTransmitterCore_pkg;

  localparam int BPSK_AMP_16 = 23170;
  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    logic sign;
    logic odd;
  } bpskSym_t;

  // Returns {iNeg, qNeg}; odd symbols rotate I by pi.
  function automatic logic [1:0] pi2BpskSigns(
    input logic sign,
    input logic odd
  );
    return {sign ^ odd, sign};
  endfunction

endpackage

// File: rtl/dvbs2_buff_bpsk_symbol_map_if.sv
// I/Q sample stream with valid/ready handshake.
// master: drives dataOutI/dataOutQ/validOut; slave: drives outReady.
interface dvbs2_buff_bpsk_symbol_map_if #(
  parameter int DATA_W = 16
);

  logic signed [DATA_W-1:0] dataOutI;
  logic signed [DATA_W-1:0] dataOutQ;
  logic                     validOut;
  logic                     outReady;

  modport master (
    output dataOutI,
    output dataOutQ,
    output validOut,
    input  outReady
  );

  modport slave (
    input  dataOutI,
    input  dataOutQ,
    input  validOut,
    output outReady
  );

endinterface

// File: rtl/dvbs2_sync_fifo_1r1w.sv
// Single-clock FIFO, one read and one write port, synchronous flush.
// Ports: clk, reset, enb, flush, wrEn/wrData, rdEn/rdData, full, empty, count.
module dvbs2_sync_fifo_1r1w #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enb,
  input  logic                     flush,
  input  logic                     wrEn,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     rdEn,
  output logic [WIDTH-1:0]         rdData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             doRd;
  logic             doWr;
  logic             memWe;
  logic [AW-1:0]    wAddr;

  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;

  assign doRd = rdEn && !empty;
  // A read in the same cycle frees the slot a full write needs.
  assign doWr = wrEn && (!full || doRd);

  // On flush a concurrent write becomes entry 0 of the new frame.
  assign memWe = enb && (flush ? wrEn : doWr);
  assign wAddr = flush ? '0 : wptr[AW-1:0];

  assign rdData = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[wAddr] <= wrData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (enb) begin
      if (flush) begin
        rptr <= '0;
        wptr <= {{AW{1'b0}}, wrEn};
      end else begin
        if (doWr) begin
          wptr <= wptr + (AW+1)'(1);
        end
        if (doRd) begin
          rptr <= rptr + (AW+1)'(1);
        end
      end
    end
  end

endmodule

// File: rtl/dvbs2_buff_bpsk_symbol_map.sv
// Buffered pi/2-BPSK symbol mapper: FIFO, parity rotation, I/Q output reg.
// Ports: clk, reset, enb, addrIn/validIn/resetIn in, outBus I/Q out, overflow, fifoCount.
module dvbs2_buff_bpsk_symbol_map
  import dvbs2hdlTransmitterCore_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int AMP        = BPSK_AMP_16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enb,
  input  logic                          addrIn,
  input  logic                          validIn,
  input  logic                          resetIn,
  dvbs2_buff_bpsk_symbol_map_if.master  outBus,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

  logic                     parity;
  bpskSym_t                 wrSym;
  bpskSym_t                 headSym;
  logic                     full;
  logic                     empty;
  logic                     load;
  logic                     drop;
  logic [1:0]               signs;
  logic signed [DATA_W-1:0] amp;
  logic signed [DATA_W-1:0] nextI;
  logic signed [DATA_W-1:0] nextQ;

  // A frame restart forces the written symbol to be even.
  assign wrSym.sign = addrIn;
  assign wrSym.odd  = resetIn ? 1'b0 : parity;

  assign load = enb && !resetIn && !empty &&
                (!outBus.validOut || outBus.outReady);
  assign drop = validIn && full && !load;

  dvbs2_sync_fifo_1r1w #(
    .WIDTH ($bits(bpskSym_t)),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk    (clk),
    .reset  (reset),
    .enb    (enb),
    .flush  (resetIn),
    .wrEn   (validIn),
    .wrData (wrSym),
    .rdEn   (load),
    .rdData (headSym),
    .full   (full),
    .empty  (empty),
    .count  (fifoCount)
  );

  assign amp   = DATA_W'(AMP);
  assign signs = pi2BpskSigns(headSym.sign, headSym.odd);
  assign nextI = signs[1] ? -amp : amp;
  assign nextQ = signs[0] ? -amp : amp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outBus.dataOutI <= '0;
      outBus.dataOutQ <= '0;
      outBus.validOut <= 1'b0;
      overflow        <= 1'b0;
      parity          <= 1'b0;
    end else if (enb) begin
      if (resetIn) begin
        outBus.validOut <= 1'b0;
        overflow        <= 1'b0;
        parity          <= validIn;
      end else begin
        // Dropped symbols still consume an index.
        if (validIn) begin
          parity <= ~parity;
        end
        if (drop) begin
          overflow <= 1'b1;
        end
        if (load) begin
          outBus.dataOutI <= nextI;
          outBus.dataOutQ <= nextQ;
          outBus.validOut <= 1'b1;
        end else if (outBus.validOut && outBus.outReady) begin
          outBus.validOut <= 1'b0;
        end
      end
    end
  end

endmodule
